// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: drains NUM_FIFO FIFOs into one shared sink.
// Round-robin grant with almost-full FIFOs served first. Each grant issues
// up to BURST_LEN pops gated by sink readiness. Underflow errors are sticky.
module fifo_drain_arbiter #(
    parameter int NUM_FIFO  = 4,
    parameter int BURST_LEN = 4,
    parameter int ID_W      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_FIFO-1:0] i_fifo_empty,
    input  logic [NUM_FIFO-1:0] i_fifo_almost_full,
    input  logic [NUM_FIFO-1:0] i_fifo_pop_err,
    input  logic                i_sink_ready,
    input  logic [NUM_FIFO-1:0] i_err_clr,
    output logic [NUM_FIFO-1:0] o_fifo_pop,
    output logic [ID_W-1:0]     o_gnt_id,
    output logic                o_burst_active,
    output logic                o_burst_done,
    output logic [NUM_FIFO-1:0] o_err_flag
);

    localparam int                CNT_W   = 4;
    localparam int                SUM_W   = ID_W + 1;
    localparam logic [CNT_W-1:0]  BL      = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  BL_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [SUM_W-1:0]  NF      = SUM_W'(NUM_FIFO);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_gnt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_active;
    logic                r_done;
    logic [NUM_FIFO-1:0] r_err;

    logic [NUM_FIFO-1:0] w_req;
    logic [NUM_FIFO-1:0] w_urg;
    logic [NUM_FIFO-1:0] w_cand;
    logic [ID_W-1:0]     w_win;
    logic [SUM_W-1:0]    w_sum;
    logic                w_gnt_empty;
    logic                w_pop_ok;

    assign w_req       = ~i_fifo_empty;
    assign w_urg       = w_req & i_fifo_almost_full;
    assign w_cand      = (|w_urg) ? w_urg : w_req;
    assign w_gnt_empty = i_fifo_empty[r_gnt];

    // Round-robin search upward from rr_ptr+1; scanning from the far end
    // lets the nearest candidate overwrite the others.
    always_comb begin
        w_win = r_rr_ptr;
        w_sum = '0;
        for (int k = NUM_FIFO; k >= 1; k--) begin
            w_sum = {1'b0, r_rr_ptr} + SUM_W'(k);
            if (w_sum >= NF) w_sum = w_sum - NF;
            if (w_cand[w_sum[ID_W-1:0]]) w_win = w_sum[ID_W-1:0];
        end
    end

    // Pop strobe to the granted FIFO only; never pops an empty FIFO.
    always_comb begin
        w_pop_ok   = (r_state == S_BURST) && i_sink_ready && !w_gnt_empty && (r_cnt < BL);
        o_fifo_pop = '0;
        if (w_pop_ok) o_fifo_pop[r_gnt] = 1'b1;
    end

    // Grant FSM: IDLE picks a winner, BURST pops, DONE pulses and advances rr_ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= ID_W'(NUM_FIFO - 1);
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (|w_req) begin
                        r_gnt    <= w_win;
                        r_cnt    <= '0;
                        r_active <= 1'b1;
                        r_state  <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_pop_ok) r_cnt <= r_cnt + 1'b1;
                    if ((w_pop_ok && r_cnt == BL_LAST) || w_gnt_empty) begin
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done   <= 1'b0;
                    r_rr_ptr <= r_gnt;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_active <= 1'b0;
                    r_done   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky underflow flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= '0;
        else        r_err <= (r_err & ~i_err_clr) | i_fifo_pop_err;
    end

    assign o_gnt_id       = r_gnt;
    assign o_burst_active = r_active;
    assign o_burst_done   = r_done;
    assign o_err_flag     = r_err;

endmodule
